// File: rtl/gumnut_pkg.sv
// Shared op codes, FSM state encoding and small decode helpers for the
// multi-cycle gumnut ALU.
package gumnut_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MASK = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL,
    ST_DONE
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

  function automatic logic is_single(input logic [3:0] op);
    return op <= OP_MASK;
  endfunction

endpackage

// File: rtl/gumnut_alu_comb.sv
// Single-cycle arithmetic/logic ops (codes 0-7); purely combinational.
module gumnut_alu_comb
  import gumnut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] res,
  output logic             c_out
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] dif_ext;
  logic [WIDTH:0] cin_ext;

  // Carry/borrow-in is only honoured for the ADDC/SUBC variants.
  always_comb begin
    cin_ext = {{WIDTH{1'b0}}, c_in & ((op == OP_ADDC) || (op == OP_SUBC))};
    sum_ext = {1'b0, a} + {1'b0, b} + cin_ext;
    dif_ext = {1'b0, a} - {1'b0, b} - cin_ext;
  end

  // Result mux; the top bit of the extended difference is the borrow.
  always_comb begin
    res   = '0;
    c_out = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin res = sum_ext[WIDTH-1:0]; c_out = sum_ext[WIDTH]; end
      OP_SUB, OP_SUBC: begin res = dif_ext[WIDTH-1:0]; c_out = dif_ext[WIDTH]; end
      OP_AND:          res = a & b;
      OP_OR:           res = a | b;
      OP_XOR:          res = a ^ b;
      OP_MASK:         res = a & ~b;
      default:         res = '0;
    endcase
  end

endmodule

// File: rtl/gumnut_alu_mc.sv
// Multi-cycle ALU: single-cycle ops via gumnut_alu_comb, bit-serial
// shifter/rotator and shift-add multiplier sequenced by a small FSM.
// Outputs are written only when entering DONE, so partial shift/multiply
// values never reach the ports.
module gumnut_alu_mc
  import gumnut_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CW-1:0]    cnt_i,
  input  logic             c_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             z_o,
  output logic             c_o,
  output logic             err_o
);

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [CW:0]      mul_cnt;

  logic [WIDTH-1:0] comb_res;
  logic             comb_c;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic             mul_ok;

  assign mul_ok  = (MUL_EN != 0);
  assign ready_o = (state == ST_IDLE);

  gumnut_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op_i),
    .a     (a_i),
    .b     (b_i),
    .c_in  (c_i),
    .res   (comb_res),
    .c_out (comb_c)
  );

  // One-bit shift/rotate step; sh_out is the bit leaving the register.
  always_comb begin
    sh_next = sr;
    sh_out  = 1'b0;
    case (op_q)
      OP_SHL: begin sh_next = {sr[WIDTH-2:0], 1'b0};      sh_out = sr[WIDTH-1]; end
      OP_SHR: begin sh_next = {1'b0, sr[WIDTH-1:1]};      sh_out = sr[0];       end
      OP_ROL: begin sh_next = {sr[WIDTH-2:0], sr[WIDTH-1]}; sh_out = sr[WIDTH-1]; end
      OP_ROR: begin sh_next = {sr[0], sr[WIDTH-1:1]};     sh_out = sr[0];       end
      default: begin sh_next = sr; sh_out = 1'b0; end
    endcase
  end

  // One shift-add step: conditionally add a to the high half, then shift
  // the whole {hi,lo} product right; b drains out of lo as the product fills in.
  always_comb begin
    mul_sum     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, a_q} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], prod_lo[WIDTH-1:1]};
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      sr          <= '0;
      rem         <= '0;
      a_q         <= '0;
      prod_hi     <= '0;
      prod_lo     <= '0;
      mul_cnt     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      result_o    <= '0;
      result_hi_o <= '0;
      z_o         <= 1'b0;
      c_o         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q <= op_i;
            if (is_shift(op_i) && (cnt_i != '0)) begin
              sr    <= a_i;
              rem   <= cnt_i;
              state <= ST_SHIFT;
            end else if ((op_i == OP_MUL) && mul_ok) begin
              a_q     <= a_i;
              prod_hi <= '0;
              prod_lo <= b_i;
              mul_cnt <= (CW+1)'(WIDTH);
              state   <= ST_MUL;
            end else begin
              state       <= ST_DONE;
              done_o      <= 1'b1;
              result_hi_o <= '0;
              if (is_single(op_i)) begin
                result_o <= comb_res;
                c_o      <= comb_c;
                z_o      <= (comb_res == '0);
                err_o    <= 1'b0;
              end else if (is_shift(op_i)) begin
                result_o <= a_i;
                c_o      <= 1'b0;
                z_o      <= (a_i == '0);
                err_o    <= 1'b0;
              end else begin
                result_o <= '0;
                c_o      <= 1'b0;
                z_o      <= 1'b1;
                err_o    <= 1'b1;
              end
            end
          end
        end
        ST_SHIFT: begin
          sr  <= sh_next;
          rem <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state       <= ST_DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b0;
            result_o    <= sh_next;
            result_hi_o <= '0;
            c_o         <= sh_out;
            z_o         <= (sh_next == '0);
          end
        end
        ST_MUL: begin
          prod_hi <= mul_hi_next;
          prod_lo <= mul_lo_next;
          mul_cnt <= mul_cnt - (CW+1)'(1);
          if (mul_cnt == (CW+1)'(1)) begin
            state       <= ST_DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b0;
            result_o    <= mul_lo_next;
            result_hi_o <= mul_hi_next;
            c_o         <= (mul_hi_next != '0);
            z_o         <= (mul_hi_next == '0) && (mul_lo_next == '0);
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gumnut_alu_mc.md
GUMNUT_ALU_MC -- requirements
Module: gumnut_alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width (legal range 4..32).
REQ-002 SHALL have parameter MUL_EN, default 1; 0 removes the multiplier, and op MUL is then treated as reserved.
REQ-003 SHALL derive localparam CW = $clog2(WIDTH) as the shift-count width.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  request; sampled only while ready_o=1.
REQ-007 op_i  in  4  operation: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 MASK (a & ~b), 8 SHL, 9 SHR, 10 ROL, 11 ROR, 12 MUL, 13-15 reserved.
REQ-008 a_i  in  WIDTH  left operand.
REQ-009 b_i  in  WIDTH  right operand.
REQ-010 cnt_i  in  CW  shift/rotate count.
REQ-011 c_i  in  1  carry/borrow in, used by ADDC/SUBC.
REQ-012 ready_o  out  1  high iff FSM is in IDLE.
REQ-013 done_o  out  1  one-cycle completion pulse.
REQ-014 result_o  out  WIDTH  result (low half for MUL).
REQ-015 result_hi_o  out  WIDTH  high half of MUL; 0 for all other ops.
REQ-016 z_o, c_o  out  1 each  zero and carry flags.
REQ-017 err_o  out  1  pulses with done_o when the op was reserved.

Function
REQ-018 Capture: op, a, b, cnt and c_i SHALL be registered on the edge where start_i=1 and ready_o=1. start_i at any other time SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, SHIFT, MUL, DONE.
REQ-020 FSM transitions SHALL be:
- IDLE->SHIFT on shift op with cnt>0.
- IDLE->MUL on MUL.
- IDLE->DONE otherwise.
- SHIFT->DONE when the remaining count reaches 0.
- MUL->DONE after WIDTH iterations.
- DONE->IDLE unconditionally.
REQ-021 done_o SHALL be high exactly during the DONE state. With start accepted at edge T, done_o SHALL be high in cycle:
- T+1 for ops 0-7, reserved ops, and shifts with cnt=0;
- T+1+cnt for shifts;
- T+1+WIDTH for MUL.
REQ-022 ADD/ADDC: {c_o,result} = a + b (+ c_i for ADDC), computed at WIDTH+1 bits.
REQ-023 SUB/SUBC: result = a - b (- c_i for SUBC); c_o=1 on borrow.
REQ-024 Logical ops SHALL force c_o=0.
REQ-025 Shifts SHALL move one bit per cycle. SHL/SHR fill with 0; ROL/ROR wrap. c_o SHALL be the last bit shifted or rotated out; cnt=0 gives result=a and c_o=0.
REQ-026 MUL SHALL be unsigned shift-add, one partial product per cycle. {result_hi_o,result_o} = a*b; c_o = (result_hi_o != 0).
REQ-027 z_o SHALL be 1 iff result_o==0, and for MUL iff both halves are 0.
REQ-028 Reserved ops SHALL give result 0, z_o=1, c_o=0, err_o=1.
REQ-029 result_o, result_hi_o, z_o and c_o SHALL update only on the DONE-entry edge and hold until the next completion. Intermediate values SHALL never be visible.
REQ-030 Changes on the inputs after capture SHALL have no effect on the operation in flight.

Reset
REQ-031 rst_i SHALL force state IDLE; result_o, result_hi_o, z_o, c_o, done_o, err_o =0; ready_o=1.
REQ-032 Reset mid-SHIFT or mid-MUL SHALL abort the operation with no done_o pulse.
REQ-033 The first start after reset release SHALL be accepted normally.

Structure
REQ-034 Op codes and the state enum SHALL live in shared package gumnut_pkg.
REQ-035 Single-cycle ops 0-7 SHALL be in sub-module gumnut_alu_comb (combinational, WIDTH-parametrised). FSM, shifter and multiplier datapath remain in gumnut_alu_mc.

Verification (WIDTH=8)
REQ-036 ADD a=0xF0, b=0x20 -> done at T+1, result 0x10, c_o=1, z_o=0.
REQ-037 SUBC a=0x05, b=0x04, c_i=1 -> result 0x00, z_o=1, c_o=0; then SUB 0x05-0x07 -> 0xFE, c_o=1.
REQ-038 ROL a=0x81, cnt=3 -> done at T+4, result 0x0C, c_o=0; ready_o=0 during T+1..T+4. SHR a=0x81, cnt=0 -> done T+1, result 0x81, c_o=0.
REQ-039 MUL a=0xFF, b=0xFF -> done at T+9, result_o=0x01, result_hi_o=0xFE, c_o=1; a second start at T+3 with ADD is ignored.
REQ-040 MUL started, rst_i pulsed at T+4 -> no done_o, all outputs 0, ready_o=1. Next ADD 1+1 -> 0x02 at T'+1.
REQ-041 op=14 -> done and err_o at T+1, result 0, z_o=1; with MUL_EN=0, op=12 behaves identically.
